avalon_wait_ram: RTL

//  Avalon-MM slave memory serving top_level_CPU's single master bus (instruction fetch + data).

---
 rtl/avalon_wait_ram.sv | 107 ++++++++++
 1 files changed

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with programmable wait states, byte-enabled writes and a side-load port.
// The array starts all-zero; programs are preloaded through the side-load port.
module avalon_wait_ram #(
    parameter int    ADDR_BITS   = 10,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // WAIT lasts exactly WAIT_CYCLES cycles so ACK lands in cycle WAIT_CYCLES+1.
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    localparam bit unused_init_file = (INIT_FILE != "");

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [31:0]          readdata_q, readdata_d;
    logic [ADDR_BITS-1:0] bus_idx;
    logic [ADDR_BITS-1:0] side_idx;
    logic                 bus_req;
    logic                 unused_bits;

    assign bus_idx     = address[ADDR_BITS+1:2];
    assign side_idx    = ADDR_BITS'(inst_addr[7:2]);
    assign bus_req     = read | write;
    assign unused_bits = &{1'b0, address[31:ADDR_BITS+2], address[1:0], inst_addr[1:0]};

    assign waitrequest = bus_req & (state_q != ST_ACK);
    assign readdata    = readdata_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_req && !inst_input) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Read data is captured on the edge entering ACK; a combined read+write is a write.
        if (state_d == ST_ACK && state_q != ST_ACK && read && !write) begin
            readdata_d = mem[bus_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            readdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
        end
    end

    // NOTE: the array has no reset; contents survive reset and only the handshake restarts.
    always_ff @(posedge clk) begin
        if (state_q == ST_ACK && write) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) mem[bus_idx][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
        // Issued last so a same-word side-load overrides a bus write on the same edge.
        if (inst_input) mem[side_idx] <= instruction;
    end

endmodule
